// File: rtl/cam_i2c_write_sequencer_if.sv
// Command and byte-stream bundle for the camera register-write sequencer.
// master = command source / byte sink, slave = the sequencer itself.
interface cam_i2c_write_sequencer_if #(
    parameter int CAM_W      = 1,
    parameter int CMD_DATA_W = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [7:0]            cmd_op;
    logic [CAM_W-1:0]      cmd_cam;
    logic [CMD_DATA_W-1:0] cmd_data;
    logic [7:0]            byte_out;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  byte_last;

    modport master (
        output cmd_valid, cmd_op, cmd_cam, cmd_data, byte_ready,
        input  cmd_ready, byte_out, byte_valid, byte_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cam, cmd_data, byte_ready,
        output cmd_ready, byte_out, byte_valid, byte_last
    );
endinterface

// File: rtl/cam_i2c_write_sequencer.sv
// Turns decoded camera commands into 3-byte I2C register writes, latches header fields, pulses triggers.
// Optional macro CAM_SEQ_ERR_CNT_EN adds a saturating o_err_count output.
module cam_i2c_write_sequencer #(
    parameter int NUM_CAMS   = 2,
    parameter int CMD_DATA_W = 64,
    parameter int GAP_CYCLES = 4,
    parameter int TRIG_PULSE = 1,
    localparam int CAM_W     = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
    input  logic                  i_sysClk,
    input  logic                  i_rst_n,
    cam_i2c_write_sequencer_if.slave bus,
    output logic                  o_busy,
    output logic                  o_cmd_err,
    output logic [NUM_CAMS-1:0]   o_trigger,
    output logic [CAM_W-1:0]      o_cam_id,
    output logic [1:0]            o_compression,
    output logic                  o_rgb,
    output logic [15:0]           o_trigger_index,
    output logic [27:0]           o_timestamp,
    output logic [10:0]           o_upper_x_val,
    output logic [11:0]           o_upper_y_val,
    output logic [10:0]           o_img_height,
    output logic [11:0]           o_img_width
`ifdef CAM_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]            o_err_count
`endif
);
    localparam logic [7:0] OP_TRIG = 8'h01;
    localparam logic [7:0] OP_EXPO = 8'h03;
    localparam logic [7:0] OP_WIN  = 8'h05;
    localparam logic [7:0] OP_SRST = 8'h0B;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (TRIG_PULSE > 1) ? $clog2(TRIG_PULSE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_op;
    logic [62:0]         r_data;
    logic [2:0]          r_widx;
    logic [1:0]          r_byte;
    logic [GW-1:0]       r_gap_cnt;
    logic [PW-1:0]       r_pulse_cnt;
    logic                r_cmd_err;
    logic [NUM_CAMS-1:0] r_trigger;
    logic [CAM_W-1:0]    r_cam_id;
    logic [1:0]          r_compression;
    logic                r_rgb;
    logic [15:0]         r_trigger_index;
    logic [27:0]         r_timestamp;
    logic [10:0]         r_upper_x_val;
    logic [11:0]         r_upper_y_val;
    logic [10:0]         r_img_height;
    logic [11:0]         r_img_width;
`ifdef CAM_SEQ_ERR_CNT_EN
    logic [7:0]          r_err_count;
`endif

    logic        w_accept, w_good, w_byte_hs, w_last_write, w_send;
    logic [23:0] w_word;
    logic [7:0]  w_byte;
    logic        w_unused_data;

    // Register write list: {reg addr, 16-bit value} for entry idx of the command kind.
    function automatic logic [23:0] write_word(input logic [7:0] op, input logic [62:0] d,
                                               input logic [2:0] idx);
        logic [23:0] w;
        w = '0;
        case (op)
            OP_EXPO: begin
                case (idx)
                    3'd0:    w = {8'h08, 12'h0, d[19:16]};
                    3'd1:    w = {8'h09, d[15:0]};
                    3'd2:    w = {8'h0C, 3'h0, d[32:20]};
                    3'd3:    w = {8'h22, 10'h0, d[34:33], 4'h0};
                    3'd4:    w = {8'h23, 10'h0, d[36:35], 4'h0};
                    3'd5:    w = {8'h05, 4'h0, d[48:37]};
                    3'd6:    w = {8'h06, 5'h0, d[59:49]};
                    default: w = '0;
                endcase
            end
            OP_WIN: begin
                case (idx)
                    3'd0:    w = {8'h01, 5'h0, d[10:0]};
                    3'd1:    w = {8'h02, 4'h0, d[22:11]};
                    3'd2:    w = {8'h03, 5'h0, d[33:23]};
                    3'd3:    w = {8'h04, 4'h0, d[45:34]};
                    default: w = '0;
                endcase
            end
            OP_SRST: w = {8'h0D, 15'h0, d[0]};
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [2:0] num_writes(input logic [7:0] op);
        case (op)
            OP_EXPO: return 3'd7;
            OP_WIN:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    assign w_unused_data = ^bus.cmd_data[CMD_DATA_W-1:63];
    assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
    assign w_good        = ((bus.cmd_op == OP_TRIG) || (bus.cmd_op == OP_EXPO) ||
                            (bus.cmd_op == OP_WIN)  || (bus.cmd_op == OP_SRST)) &&
                           (32'(bus.cmd_cam) < NUM_CAMS);
    assign w_send        = (r_state == S_SEND);
    assign w_byte_hs     = w_send && bus.byte_ready;
    assign w_word        = write_word(r_op, r_data, r_widx);
    assign w_byte        = (r_byte == 2'd0) ? w_word[23:16] :
                           (r_byte == 2'd1) ? w_word[15:8]  : w_word[7:0];
    assign w_last_write  = (r_widx == (num_writes(r_op) - 3'd1));

    always_ff @(posedge i_sysClk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.cmd_ready  = (r_state == S_IDLE);
        bus.byte_valid = w_send;
        bus.byte_out   = w_send ? w_byte : 8'h00;
        bus.byte_last  = w_send && (r_byte == 2'd2);
        case (r_state)
            S_IDLE: if (w_accept && w_good)
                        w_state_nxt = (bus.cmd_op == OP_TRIG) ? S_DONE : S_LOAD;
            S_LOAD: w_state_nxt = S_SEND;
            S_SEND: if (w_byte_hs && (r_byte == 2'd2))
                        w_state_nxt = w_last_write ? S_DONE :
                                      ((GAP_CYCLES == 0) ? S_SEND : S_GAP);
            S_GAP:  if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_nxt = S_SEND;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysClk) begin
        if (!i_rst_n) begin
            r_op            <= '0;
            r_data          <= '0;
            r_widx          <= '0;
            r_byte          <= '0;
            r_gap_cnt       <= '0;
            r_pulse_cnt     <= '0;
            r_cmd_err       <= 1'b0;
            r_trigger       <= '0;
            r_cam_id        <= '0;
            r_compression   <= '0;
            r_rgb           <= 1'b0;
            r_trigger_index <= '0;
            r_timestamp     <= '0;
            r_upper_x_val   <= '0;
            r_upper_y_val   <= '0;
            r_img_height    <= '0;
            r_img_width     <= '0;
`ifdef CAM_SEQ_ERR_CNT_EN
            r_err_count     <= '0;
`endif
        end else begin
            r_cmd_err <= w_accept && !w_good;
`ifdef CAM_SEQ_ERR_CNT_EN
            if (w_accept && !w_good && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
`endif
            if (w_accept && w_good) begin
                r_cam_id <= bus.cmd_cam;
                r_op     <= bus.cmd_op;
                r_data   <= bus.cmd_data[62:0];
                r_widx   <= '0;
                r_byte   <= '0;
                if (bus.cmd_op == OP_TRIG) begin
                    r_trigger_index <= bus.cmd_data[15:0];
                    r_timestamp     <= bus.cmd_data[43:16];
                end
            end
            if (r_state == S_LOAD) begin
                case (r_op)
                    OP_EXPO: begin
                        r_compression <= r_data[61:60];
                        r_rgb         <= r_data[62];
                    end
                    OP_WIN: begin
                        r_upper_x_val <= r_data[10:0];
                        r_upper_y_val <= r_data[22:11];
                        r_img_height  <= r_data[33:23];
                        r_img_width   <= r_data[45:34];
                    end
                    default: ;
                endcase
            end
            // Byte position only moves on an accepted byte; a stalled byte stays put.
            if (w_byte_hs) begin
                if (r_byte == 2'd2) begin
                    r_byte <= '0;
                    r_widx <= r_widx + 3'd1;
                end else begin
                    r_byte <= r_byte + 2'd1;
                end
            end
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GW'(1) : '0;
            if (w_accept && w_good && (bus.cmd_op == OP_TRIG)) begin
                r_trigger   <= NUM_CAMS'(1) << bus.cmd_cam;
                r_pulse_cnt <= PW'(TRIG_PULSE - 1);
            end else if (r_trigger != '0) begin
                if (r_pulse_cnt == '0) r_trigger   <= '0;
                else                   r_pulse_cnt <= r_pulse_cnt - PW'(1);
            end
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_cmd_err       = r_cmd_err;
    assign o_trigger       = r_trigger;
    assign o_cam_id        = r_cam_id;
    assign o_compression   = r_compression;
    assign o_rgb           = r_rgb;
    assign o_trigger_index = r_trigger_index;
    assign o_timestamp     = r_timestamp;
    assign o_upper_x_val   = r_upper_x_val;
    assign o_upper_y_val   = r_upper_y_val;
    assign o_img_height    = r_img_height;
    assign o_img_width     = r_img_width;
`ifdef CAM_SEQ_ERR_CNT_EN
    assign o_err_count     = r_err_count;
`endif
endmodule

// File: tb/tb_cam_i2c_write_sequencer.sv
// Bench for cam_i2c_write_sequencer: command vector table plus hand-built window/exposure/abort sequences.
// Three cameras are instantiated so that an out-of-range camera index is representable.
module tb_cam_i2c_write_sequencer;
    localparam int NUM_CAMS   = 3;
    localparam int CAM_W      = 2;
    localparam int GAP_CYCLES = 4;
    localparam int TRIG_PULSE = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cam_i2c_write_sequencer_if #(.CAM_W(CAM_W), .CMD_DATA_W(64)) bus();

    logic                busy, cmd_err, rgb;
    logic [NUM_CAMS-1:0] trigger;
    logic [CAM_W-1:0]    cam_id;
    logic [1:0]          compression;
    logic [15:0]         trigger_index;
    logic [27:0]         timestamp;
    logic [10:0]         upper_x_val, img_height;
    logic [11:0]         upper_y_val, img_width;
`ifdef CAM_SEQ_ERR_CNT_EN
    logic [7:0]          err_count;
`endif

    cam_i2c_write_sequencer #(
        .NUM_CAMS(NUM_CAMS), .CMD_DATA_W(64), .GAP_CYCLES(GAP_CYCLES), .TRIG_PULSE(TRIG_PULSE)
    ) dut (
        .i_sysClk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_busy(busy), .o_cmd_err(cmd_err), .o_trigger(trigger), .o_cam_id(cam_id),
        .o_compression(compression), .o_rgb(rgb), .o_trigger_index(trigger_index),
        .o_timestamp(timestamp), .o_upper_x_val(upper_x_val), .o_upper_y_val(upper_y_val),
        .o_img_height(img_height), .o_img_width(img_width)
`ifdef CAM_SEQ_ERR_CNT_EN
        , .o_err_count(err_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_bytes[$];
    bit         q_last[$];
    int         q_gaps[$];
    int         n_errp, trig_cyc, first_valid;
    logic [NUM_CAMS-1:0] trig_or;
    bit         busy_seen;

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  cam;
        logic [63:0] data;
        int          n_err;
        int          n_bytes;
        logic [2:0]  trig;
        int          t_cyc;
        bit          busy;
        logic [1:0]  cam_id;
        logic [7:0]  b0;
        logic [7:0]  b2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and observe until the sequencer is idle again.
    task automatic run_cmd(input logic [7:0] op, input logic [1:0] cam, input logic [63:0] data,
                           input bit stall, input bit junk);
        int gap;
        bit in_gap, done, pv, pr, pl;
        logic [7:0] pb;
        q_bytes.delete(); q_last.delete(); q_gaps.delete();
        n_errp = 0; trig_cyc = 0; trig_or = '0; busy_seen = 0; first_valid = -1;
        gap = 0; in_gap = 0; done = 0; pv = 0; pr = 0; pl = 0; pb = 8'h00;
        bus.cmd_op = op; bus.cmd_cam = cam; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        bus.byte_ready = !stall;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            tick();
            if (!junk || bus.cmd_ready) bus.cmd_valid = 1'b0;
            else                        bus.cmd_op    = 8'h07;
            if (cmd_err) n_errp++;
            if (trigger != '0) begin trig_or |= trigger; trig_cyc++; end
            if (busy) busy_seen = 1;
            if (pv && !pr) begin
                check("stall_hold", {bus.byte_valid, bus.byte_last, bus.byte_out}, {1'b1, pl, pb});
            end
            if (in_gap) begin
                if (!bus.byte_valid) gap++;
                else begin q_gaps.push_back(gap); in_gap = 0; gap = 0; end
            end
            if (stall) bus.byte_ready = ((cyc % 3) == 2);
            if (bus.byte_valid && first_valid < 0) first_valid = cyc;
            if (bus.byte_valid && bus.byte_ready) begin
                q_bytes.push_back(bus.byte_out);
                q_last.push_back(bus.byte_last);
                if (bus.byte_last) in_gap = 1;
            end
            pv = bus.byte_valid; pr = bus.byte_ready; pl = bus.byte_last; pb = bus.byte_out;
            if (cyc >= 2 && bus.cmd_ready) done = 1;
        end
        bus.cmd_valid = 1'b0;
        bus.byte_ready = 1'b1;
        check("cmd_complete", 64'(done), 64'd1);
    endtask

    logic [7:0]  exp_win[12];
    logic [7:0]  exp_exp[21];
    logic [63:0] wdata, edata, tdata;
    int          hs;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wdata = (64'hABC << 34) | 64'h123;
        edata = (64'h5 << 16) | 64'h1234 | (64'h1ABC << 20) | (64'h2 << 33) | (64'h3 << 35) |
                (64'h987 << 37) | (64'h5A5 << 49) | (64'h2 << 60) | (64'h1 << 62);
        tdata = (64'h1234567 << 16) | 64'h0042;
        exp_win = '{8'h01, 8'h01, 8'h23, 8'h02, 8'h00, 8'h00,
                    8'h03, 8'h00, 8'h00, 8'h04, 8'h0A, 8'hBC};
        exp_exp = '{8'h08, 8'h00, 8'h05, 8'h09, 8'h12, 8'h34, 8'h0C, 8'h1A, 8'hBC,
                    8'h22, 8'h00, 8'h20, 8'h23, 8'h00, 8'h30, 8'h05, 8'h09, 8'h87,
                    8'h06, 8'h05, 8'hA5};
        //            op     cam   data    err nb trig    tcyc        busy cam_id b0     b2
        vecs[0] = '{8'h07, 2'd0, 64'h0,   1,  0, 3'b000, 0,          1'b0, 2'd0, 8'h00, 8'h00};
        vecs[1] = '{8'h05, 2'd3, 64'h0,   1,  0, 3'b000, 0,          1'b0, 2'd0, 8'h00, 8'h00};
        vecs[2] = '{8'h0B, 2'd1, 64'h1,   0,  3, 3'b000, 0,          1'b1, 2'd1, 8'h0D, 8'h01};
        vecs[3] = '{8'h01, 2'd2, 64'h7,   0,  0, 3'b100, TRIG_PULSE, 1'b1, 2'd2, 8'h00, 8'h00};
        vecs[4] = '{8'h00, 2'd1, 64'h0,   1,  0, 3'b000, 0,          1'b0, 2'd2, 8'h00, 8'h00};
        vecs[5] = '{8'h01, 2'd0, tdata,   0,  0, 3'b001, TRIG_PULSE, 1'b1, 2'd0, 8'h00, 8'h00};
        vecs[6] = '{8'h0B, 2'd3, 64'h1,   1,  0, 3'b000, 0,          1'b0, 2'd0, 8'h00, 8'h00};
        vecs[7] = '{8'h0B, 2'd2, 64'h0,   0,  3, 3'b000, 0,          1'b1, 2'd2, 8'h0D, 8'h00};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 8'h00; bus.cmd_cam = '0; bus.cmd_data = '0;
        bus.byte_ready = 1'b1;
        tick(); tick();
        check("rst_ctrl", {bus.cmd_ready, busy, cmd_err, bus.byte_valid, bus.byte_last, trigger},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000});
        check("rst_byte_out", 64'(bus.byte_out), 64'h0);
        check("rst_hdr_a", {cam_id, compression, rgb, trigger_index, timestamp}, 64'h0);
        check("rst_hdr_b", {upper_x_val, upper_y_val, img_height, img_width}, 64'h0);
`ifdef CAM_SEQ_ERR_CNT_EN
        check("rst_err_count", 64'(err_count), 64'h0);
`endif
        rst_n = 1'b1;
        tick();

        // Window, cam 1, free-flowing byte_ready.
        run_cmd(8'h05, 2'd1, wdata, 1'b0, 1'b0);
        check("win_nbytes", 64'(q_bytes.size()), 64'd12);
        for (int i = 0; i < q_bytes.size() && i < 12; i++) begin
            check($sformatf("win_byte%0d", i), 64'(q_bytes[i]), 64'(exp_win[i]));
            check($sformatf("win_last%0d", i), 64'(q_last[i]), 64'((i % 3) == 2));
        end
        check("win_ngaps", 64'(q_gaps.size()), 64'd3);
        foreach (q_gaps[i]) check($sformatf("win_gap%0d", i), 64'(q_gaps[i]), 64'(GAP_CYCLES));
        check("win_first_lat", 64'(first_valid), 64'd1);
        check("win_cam_id", 64'(cam_id), 64'd1);
        check("win_hdr", {upper_x_val, upper_y_val, img_height, img_width},
              {11'h123, 12'h000, 11'h000, 12'hABC});

        // Exposure, cam 0, byte_ready high one cycle in three.
        run_cmd(8'h03, 2'd0, edata, 1'b1, 1'b0);
        check("exp_nbytes", 64'(q_bytes.size()), 64'd21);
        for (int i = 0; i < q_bytes.size() && i < 21; i++)
            check($sformatf("exp_byte%0d", i), 64'(q_bytes[i]), 64'(exp_exp[i]));
        foreach (q_gaps[i]) check($sformatf("exp_gap%0d", i), 64'(q_gaps[i]), 64'(GAP_CYCLES));
        check("exp_hdr", {compression, rgb, 2'(cam_id)}, {2'b10, 1'b1, 2'd0});
        check("exp_win_hold", 64'(img_width), 64'hABC);

        for (int v = 0; v < 8; v++) begin
            run_cmd(vecs[v].op, vecs[v].cam, vecs[v].data, 1'b0, 1'b0);
            check($sformatf("v%0d_err", v), 64'(n_errp), 64'(vecs[v].n_err));
            check($sformatf("v%0d_nbytes", v), 64'(q_bytes.size()), 64'(vecs[v].n_bytes));
            check($sformatf("v%0d_trig", v), 64'(trig_or), 64'(vecs[v].trig));
            check($sformatf("v%0d_tcyc", v), 64'(trig_cyc), 64'(vecs[v].t_cyc));
            check($sformatf("v%0d_busy", v), 64'(busy_seen), 64'(vecs[v].busy));
            check($sformatf("v%0d_cam_id", v), 64'(cam_id), 64'(vecs[v].cam_id));
            if (q_bytes.size() == 3) begin
                check($sformatf("v%0d_b0", v), 64'(q_bytes[0]), 64'(vecs[v].b0));
                check($sformatf("v%0d_b2", v), 64'(q_bytes[2]), 64'(vecs[v].b2));
            end
        end
        check("trig_index", 64'(trigger_index), 64'h0042);
        check("trig_timestamp", 64'(timestamp), 64'h1234567);
        check("exp_hdr_hold", {compression, rgb}, {2'b10, 1'b1});
`ifdef CAM_SEQ_ERR_CNT_EN
        check("err_count", 64'(err_count), 64'd4);
`endif

        // Window while cmd_valid stays asserted with a bad opcode during busy.
        run_cmd(8'h05, 2'd0, wdata, 1'b0, 1'b1);
        check("junk_err", 64'(n_errp), 64'd0);
        check("junk_nbytes", 64'(q_bytes.size()), 64'd12);

        // Reset after the 5th exposure byte, then a fresh soft-reset command.
        hs = 0;
        bus.cmd_op = 8'h03; bus.cmd_cam = 2'd1; bus.cmd_data = edata; bus.cmd_valid = 1'b1;
        bus.byte_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 100 && hs < 5; c++) begin
            if (bus.byte_valid && bus.byte_ready) hs++;
            tick();
        end
        check("abort_hs", 64'(hs), 64'd5);
        rst_n = 1'b0;
        tick();
        check("abort_state", {bus.byte_valid, busy, bus.cmd_ready}, {1'b0, 1'b0, 1'b1});
        check("abort_hdr", {compression, rgb, 2'(cam_id)}, 64'h0);
        rst_n = 1'b1;
        tick();
        run_cmd(8'h0B, 2'd1, 64'h1, 1'b0, 1'b0);
        check("after_abort_nbytes", 64'(q_bytes.size()), 64'd3);
        if (q_bytes.size() == 3)
            check("after_abort_bytes", {q_bytes[0], q_bytes[1], q_bytes[2]}, 64'h0D0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
